// File: rtl/cw_replay_buf.sv
// ============================================================================
// cw_replay_buf -- parametrised codeword replay buffer (OFDM receive path)
//
// Captures one block of DEPTH received codewords. It then replays the whole
// block N_ITER times to the iterative decoder. Both sides use ready/valid flow
// control. The storage is an inferred simple dual-port RAM with a 1-cycle
// registered read.
//
// Optional feature macro: CW_REPLAY_ITER_TAG_EN
//   defined     -> do_iter port present; it carries the pass index of do_data.
//   not defined -> do_iter port absent; the pass counter stays internal.
//
// Parameters
//   DW      codeword width (bits)
//   DEPTH   codewords per block (>= 2)
//   AW      address width (2**AW >= DEPTH)
//   N_ITER  replay passes per block (>= 1)
//   IW      pass-counter width (2**IW >= N_ITER)
//
// Ports
//   clk      in   1   working clock
//   rst      in   1   reset, asynchronous, active-high
//   di       in   DW  input codeword
//   di_vld   in   1   input valid
//   di_rdy   out  1   buffer accepts input (fill phase)
//   do_data  out  DW  replayed codeword (registered RAM read data).
//                     'do' is a reserved word, so this port is named do_data.
//   do_vld   out  1   output valid
//   do_rdy   in   1   downstream accepts output
//   do_last  out  1   do_data is word DEPTH-1 of the current pass
//   do_iter  out  IW  pass index of do_data (CW_REPLAY_ITER_TAG_EN only)
//   done     out  1   1-cycle pulse: final word of final pass accepted
// ============================================================================
module cw_replay_buf #(
    parameter int DW     = 3,
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int N_ITER = 4,
    parameter int IW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] di,
    input  logic          di_vld,
    output logic          di_rdy,
    output logic [DW-1:0] do_data,
    output logic          do_vld,
    input  logic          do_rdy,
    output logic          do_last,
`ifdef CW_REPLAY_ITER_TAG_EN
    output logic [IW-1:0] do_iter,
`endif
    output logic          done
);

    localparam int            RW          = $clog2(DEPTH * N_ITER + 1);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
    localparam logic [RW-1:0] TOTAL_WORDS = RW'(DEPTH * N_ITER);

    // S_ARM is the one cycle between the last write and the first read issue.
    // During that cycle the read counter is loaded, so the first output word
    // appears on the 2nd edge after the final write.
    typedef enum logic [1:0] {
        S_FILL,
        S_ARM,
        S_REPLAY
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] pass;
    logic [RW-1:0] reads_left;
    logic          wr_en, rd_en, last_accept;
    logic [DW-1:0] mem [DEPTH];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: clocked state is always assigned with <=, so every flop samples
    // the values that held before the edge, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FILL;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first. A path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:   if (wr_en && (wr_ptr == LAST_ADDR)) state_nxt = S_ARM;
            S_ARM:    state_nxt = S_REPLAY;
            S_REPLAY: if (last_accept) state_nxt = S_FILL;
            default:  state_nxt = S_FILL;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        wr_en       = (state == S_FILL) && di_vld && di_rdy;
        // A new read is issued when reads remain and the output register is
        // empty or being emptied this cycle.
        rd_en       = (state == S_REPLAY) && (reads_left != '0) &&
                      (!do_vld || do_rdy);
        // Once every read has been issued, the only word left in flight is
        // the final word of the final pass.
        last_accept = (state == S_REPLAY) && (reads_left == '0) &&
                      do_vld && do_rdy && do_last;
    end

    // ------------------------------------------------------------------------
    // Codeword RAM write port
    // ------------------------------------------------------------------------
    // NOTE: the storage array has no reset, so it can map onto block RAM.
    // Its contents are don't-care until a block has been written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= di;
    end

    // ------------------------------------------------------------------------
    // Pointers, counters and registered output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            di_rdy     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pass       <= '0;
            reads_left <= '0;
            do_data    <= '0;
            do_vld     <= 1'b0;
            do_last    <= 1'b0;
            done       <= 1'b0;
`ifdef CW_REPLAY_ITER_TAG_EN
            do_iter    <= '0;
`endif
        end else begin
            // di_rdy is registered from the next state. It rises on the first
            // edge after reset and drops on the edge that takes the last word.
            di_rdy <= (state_nxt == S_FILL);
            done   <= last_accept;

            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
            end

            if (state == S_ARM) begin
                reads_left <= TOTAL_WORDS;
            end

            if (rd_en) begin
                do_data    <= mem[rd_ptr];
                do_vld     <= 1'b1;
                do_last    <= (rd_ptr == LAST_ADDR);
`ifdef CW_REPLAY_ITER_TAG_EN
                do_iter    <= pass;
`endif
                reads_left <= reads_left - RW'(1);
                if (rd_ptr == LAST_ADDR) begin
                    rd_ptr <= '0;
                    pass   <= pass + IW'(1);
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end else if (do_vld && do_rdy) begin
                do_vld <= 1'b0;
            end

            // The last read already wrapped rd_ptr to 0. Rewind the pass count
            // so the next block starts clean.
            if (last_accept) begin
                pass <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cw_replay_buf.sv
// ============================================================================
// tb_cw_replay_buf -- self-checking bench for cw_replay_buf
//
// u_dut  : default configuration (DW=3, DEPTH=32, N_ITER=4).
// u_dut5 : small configuration (DW=6, DEPTH=8, AW=3, N_ITER=1, IW=1).
// When CW_REPLAY_ITER_TAG_EN is defined, the pass tag is checked as well.
// ============================================================================
`timescale 1ns/1ps
module tb_cw_replay_buf;

    // ------------------------------------------------------------------------
    // Default-configuration DUT
    // ------------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] di;
    logic       di_vld;
    logic       di_rdy;
    logic [2:0] do_data;
    logic       do_vld;
    logic       do_rdy;
    logic       do_last;
    logic       done;
`ifdef CW_REPLAY_ITER_TAG_EN
    logic [1:0] do_iter;
`endif

    cw_replay_buf u_dut (
        .clk     (clk),
        .rst     (rst),
        .di      (di),
        .di_vld  (di_vld),
        .di_rdy  (di_rdy),
        .do_data (do_data),
        .do_vld  (do_vld),
        .do_rdy  (do_rdy),
        .do_last (do_last),
`ifdef CW_REPLAY_ITER_TAG_EN
        .do_iter (do_iter),
`endif
        .done    (done)
    );

    // ------------------------------------------------------------------------
    // Small-configuration DUT
    // ------------------------------------------------------------------------
    logic [5:0] di5;
    logic       di_vld5;
    logic       di_rdy5;
    logic [5:0] do_data5;
    logic       do_vld5;
    logic       do_rdy5;
    logic       do_last5;
    logic       done5;
`ifdef CW_REPLAY_ITER_TAG_EN
    logic [0:0] do_iter5;
`endif

    cw_replay_buf #(.DW(6), .DEPTH(8), .AW(3), .N_ITER(1), .IW(1)) u_dut5 (
        .clk     (clk),
        .rst     (rst),
        .di      (di5),
        .di_vld  (di_vld5),
        .di_rdy  (di_rdy5),
        .do_data (do_data5),
        .do_vld  (do_vld5),
        .do_rdy  (do_rdy5),
        .do_last (do_last5),
`ifdef CW_REPLAY_ITER_TAG_EN
        .do_iter (do_iter5),
`endif
        .done    (done5)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Vector table: input codeword plus the expected replay output for it
    // ------------------------------------------------------------------------
    typedef struct {
        logic [2:0] di;
        logic [2:0] exp_do;
        logic       exp_last;
    } vec_t;

    vec_t tbl [32];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fill the table with codeword (k*mult + add) mod 8.
    task automatic set_tbl(input int mult, input int add);
        for (int k = 0; k < 32; k++) begin
            tbl[k].di       = 3'((k * mult + add) % 8);
            tbl[k].exp_do   = 3'((k * mult + add) % 8);
            tbl[k].exp_last = (k == 31);
        end
    endtask

    // Write one 32-word block from the table. Each word is accepted on the
    // next edge, because di_rdy stays high for the whole fill phase.
    task automatic fill(input bit gap);
        check("fill_di_rdy_high", di_rdy, 1);
        for (int k = 0; k < 32; k++) begin
            di     = tbl[k].di;
            di_vld = 1'b1;
            @(posedge clk); #1;
            if (gap) begin
                di_vld = 1'b0;
                @(posedge clk); #1;
            end
        end
        di_vld = 1'b0;
    endtask

    // Collect n_words output handshakes and compare each one against the
    // table. Optionally hold do_rdy low for stall_len cycles when word
    // stall_at is presented. With full_block set, also check the done pulse
    // and the return to fill.
    task automatic drain(input int n_words, input int stall_at,
                         input int stall_len, input bit full_block);
        int got    = 0;
        int cyc    = 0;
        int stalls = 0;
        int early  = 0;
        check("replay_di_rdy_low", di_rdy, 0);
        while (got < n_words && cyc < 4000) begin
            if (got == stall_at && do_vld && stalls < stall_len) begin
                do_rdy = 1'b0;
                stalls++;
                check("stall_hold_data", do_data, tbl[got % 32].exp_do);
                check("stall_hold_vld", do_vld, 1);
            end else begin
                do_rdy = 1'b1;
            end
            if (done) early++;
            if (do_vld && do_rdy) begin
                check("do_data", do_data, tbl[got % 32].exp_do);
                check("do_last", do_last, tbl[got % 32].exp_last);
`ifdef CW_REPLAY_ITER_TAG_EN
                check("do_iter", do_iter, got / 32);
`endif
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_word_count", got, n_words);
        check("no_early_done", early, 0);
        if (full_block) begin
            check("done_pulse", done, 1);
            check("di_rdy_back", di_rdy, 1);
            check("no_bubble_vld", do_vld, 0);
            di_vld = 1'b0;
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
            check("no_extra_word", do_vld, 0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Safety net against a hung run
    // ------------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [5:0] d5 [8];
        int         got5;
        int         cyc5;

        rst     = 1'b1;
        di      = '0;
        di_vld  = 1'b0;
        do_rdy  = 1'b0;
        di5     = '0;
        di_vld5 = 1'b0;
        do_rdy5 = 1'b1;

        // Reset state.
        #2;
        check("rst_di_rdy", di_rdy, 0);
        check("rst_do", do_data, 0);
        check("rst_do_vld", do_vld, 0);
        check("rst_do_last", do_last, 0);
        check("rst_done", done, 0);
`ifdef CW_REPLAY_ITER_TAG_EN
        check("rst_do_iter", do_iter, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        check("rel_di_rdy_still_low", di_rdy, 0);
        @(posedge clk); #1;
        check("rel_di_rdy_rises", di_rdy, 1);
        check("rel_di_rdy5_rises", di_rdy5, 1);

        // Test 1: k%8 pattern, full-rate replay, with a latency check.
        set_tbl(1, 0);
        fill(1'b0);
        do_rdy = 1'b0;
        check("lat_vld_low_e0", do_vld, 0);
        @(posedge clk); #1;
        check("lat_vld_low_e1", do_vld, 0);
        @(posedge clk); #1;
        check("lat_vld_high_e2", do_vld, 1);
        check("lat_first_word", do_data, tbl[0].exp_do);
        drain(128, -1, 0, 1'b1);

        // Test 2: 3-cycle stall at pass 1 word 10.
        fill(1'b0);
        drain(128, 32 + 10, 3, 1'b1);

        // Test 3: di_vld held high with di=7 throughout replay.
        set_tbl(5, 2);
        fill(1'b0);
        di     = 3'd7;
        di_vld = 1'b1;
        drain(128, -1, 0, 1'b1);

        // Test 4: reset at pass 2 word 5, then a new block replays new data only.
        set_tbl(7, 4);
        fill(1'b0);
        drain(69, -1, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_di_rdy", di_rdy, 0);
        check("midrst_do", do_data, 0);
        check("midrst_do_vld", do_vld, 0);
        check("midrst_do_last", do_last, 0);
        check("midrst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_rel_di_rdy_low", di_rdy, 0);
        @(posedge clk); #1;
        check("midrst_rel_di_rdy_high", di_rdy, 1);
        set_tbl(3, 1);
        fill(1'b0);
        drain(128, -1, 0, 1'b1);

        // Test 5: small configuration, gapped input, single pass.
        for (int k = 0; k < 8; k++) d5[k] = 6'((k * 9 + 3) % 64);
        check("t5_di_rdy_high", di_rdy5, 1);
        for (int k = 0; k < 8; k++) begin
            di5     = d5[k];
            di_vld5 = 1'b1;
            @(posedge clk); #1;
            di_vld5 = 1'b0;
            @(posedge clk); #1;
        end
        got5 = 0;
        cyc5 = 0;
        do_rdy5 = 1'b1;
        while (got5 < 8 && cyc5 < 200) begin
            if (do_vld5) begin
                check("t5_do", do_data5, d5[got5]);
                check("t5_do_last", do_last5, (got5 == 7) ? 1 : 0);
                got5++;
            end
            @(posedge clk); #1;
            cyc5++;
        end
        check("t5_word_count", got5, 8);
        check("t5_done_pulse", done5, 1);
        check("t5_di_rdy_back", di_rdy5, 1);
        @(posedge clk); #1;
        check("t5_done_one_cycle", done5, 0);
        check("t5_no_extra_word", do_vld5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
